// File: rtl/fb_scanout_reader_pkg.sv
// Shared types and constants for the framebuffer scan-out reader.
// Latency/backpressure: n/a (definitions only).
package fb_scanout_reader_pkg;

  localparam int H_RES_DEF  = 1280;
  localparam int V_RES_DEF  = 720;
  localparam int ADDR_W_DEF = 20;
  localparam int RD_LAT_DEF = 2;

  localparam logic [7:0] GRAY_STEP = 8'd17;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACTIVE,
    H_BLANK
  } state_t;

  // Per-pixel control travelling alongside the BRAM read.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic vld;
  } ctl_t;

  // Expands a 4-bit code to a full-range 8-bit level (0 -> 0, 15 -> 255).
  function automatic logic [7:0] gray_level(input logic [3:0] code);
    return {4'b0000, code} * GRAY_STEP;
  endfunction

endpackage

// File: rtl/fb_scanout_reader_if.sv
// Framebuffer BRAM read port (port B): enable/address out, 4-bit code back.
// Fixed-latency read, no backpressure.
interface fb_scanout_reader_if #(
  parameter int ADDR_W = 20
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        dout;

  modport master (output en, output addr, input dout);
  modport slave  (input en, input addr, output dout);
endinterface

// File: rtl/fb_palette.sv
// Registered code->RGB map, one cycle; gray by default, colour when FB_SCANOUT_COLOR_EN is defined.
// No backpressure; invalid pixels map to black.
module fb_palette
  import fb_scanout_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vld,
  input  logic [3:0] code,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  logic [7:0] red_d, green_d, blue_d;
  logic [7:0] red_q, green_q, blue_q;
  logic [7:0] lvl;

  always_comb begin
    lvl     = gray_level(code);
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (vld) begin
`ifdef FB_SCANOUT_COLOR_EN
      // Blue ramps twice as fast over the lower half, then saturates.
      red_d   = lvl;
      green_d = gray_level(~code);
      blue_d  = code[3] ? 8'hFF : {lvl[6:0], 1'b0};
`else
      red_d   = lvl;
      green_d = lvl;
      blue_d  = lvl;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out: HDMI timing -> BRAM port-B reads -> RGB; RD_LAT+1 cycles in to out.
// No backpressure (pixel-rate stream); palette variant selected by FB_SCANOUT_COLOR_EN.
module fb_scanout_reader
  import fb_scanout_reader_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         sx,
  input  logic [15:0]         sy,
  input  logic                de_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  fb_scanout_reader_if.master bram,
  output logic [7:0]          o_red,
  output logic [7:0]          o_green,
  output logic [7:0]          o_blue,
  output logic                o_de,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_sync_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base, nxt_base;
  logic [15:0]       line_cnt_q, line_cnt_d, nxt_cnt;
  logic              scan, rd_en, last_line;
  logic              sync_err_q, sync_err_d;
  ctl_t [RD_LAT-1:0] ctl_q, ctl_d;
  logic              o_de_q, o_de_d;
  logic              o_hsync_q, o_hsync_d;
  logic              o_vsync_q, o_vsync_d;

  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    line_cnt_d  = line_cnt_q;
    sync_err_d  = 1'b0;
    scan        = 1'b0;
    base        = line_base_q;
    // Line base accumulates by H_RES per line; wraps to 0 after the last line.
    last_line   = (line_cnt_q >= 16'(V_RES - 1));
    nxt_cnt     = last_line ? '0 : line_cnt_q + 16'd1;
    nxt_base    = last_line ? '0 : line_base_q + ADDR_W'(H_RES);

    unique case (state_q)
      WAIT_FRAME: begin
        if (de_in && sx == '0 && sy == '0) begin
          state_d     = ACTIVE;
          line_base_d = '0;
          line_cnt_d  = '0;
          base        = '0;
          scan        = 1'b1;
        end
      end
      ACTIVE: begin
        if (de_in) scan = 1'b1;
        else       state_d = H_BLANK;
      end
      H_BLANK: begin
        if (de_in) begin
          if (sx != '0 || sy != nxt_cnt) begin
            sync_err_d = 1'b1;
            state_d    = WAIT_FRAME;
          end else begin
            state_d     = ACTIVE;
            line_base_d = nxt_base;
            line_cnt_d  = nxt_cnt;
            base        = nxt_base;
            scan        = 1'b1;
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase

    rd_en  = scan && (sx < 16'(H_RES));
    addr_d = scan ? base + ADDR_W'(sx) : addr_q;
  end

  // Control rides alongside the BRAM read so it lines up with doutb.
  always_comb begin
    ctl_d[0] = '{de: de_in, hsync: hsync_in, vsync: vsync_in, vld: rd_en};
    for (int i = 1; i < RD_LAT; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
    o_de_d    = ctl_q[RD_LAT-1].de;
    o_hsync_d = ctl_q[RD_LAT-1].hsync;
    o_vsync_d = ctl_q[RD_LAT-1].vsync;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= WAIT_FRAME;
      line_base_q <= '0;
      line_cnt_q  <= '0;
      addr_q      <= '0;
      sync_err_q  <= 1'b0;
      ctl_q       <= '0;
      o_de_q      <= 1'b0;
      o_hsync_q   <= 1'b0;
      o_vsync_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      line_cnt_q  <= line_cnt_d;
      addr_q      <= addr_d;
      sync_err_q  <= sync_err_d;
      ctl_q       <= ctl_d;
      o_de_q      <= o_de_d;
      o_hsync_q   <= o_hsync_d;
      o_vsync_q   <= o_vsync_d;
    end
  end

  fb_palette u_palette (
    .clk   (clk),
    .rst   (rst),
    .vld   (ctl_q[RD_LAT-1].vld),
    .code  (bram.dout),
    .red   (o_red),
    .green (o_green),
    .blue  (o_blue)
  );

  assign bram.en    = rd_en;
  assign bram.addr  = addr_d;
  assign o_de       = o_de_q;
  assign o_hsync    = o_hsync_q;
  assign o_vsync    = o_vsync_q;
  assign o_sync_err = sync_err_q;

endmodule
